// File: rtl/lfsr_pkg.sv
// Shared constants and FSM encoding for the Galois LFSR keystream generator.
// Polynomial x^16+x^14+x^13+x^11+1 (maximal period 65535).
package lfsr_pkg;

  localparam int          LFSR_WIDTH   = 16;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFSEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ks_state_e;

endpackage

// File: rtl/ks_byte_pack.sv
// Serial-to-parallel byte assembler: first shifted bit lands in byte_data[0].
// byte_valid is a registered one-cycle pulse after the 8th shift; clear drops the partial byte.
module ks_byte_pack (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       shift,
  input  logic       clear,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  logic [2:0] bit_cnt_q,    bit_cnt_d;
  logic [7:0] shreg_q,      shreg_d;
  logic [7:0] byte_data_q,  byte_data_d;
  logic       byte_valid_q, byte_valid_d;

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    if (clear) begin
      bit_cnt_d = 3'd0;
      shreg_d   = 8'h00;
    end else if (shift) begin
      // Shift right so the earliest bit migrates down to bit 0 by the 8th shift.
      shreg_d   = {bit_in, shreg_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_data_d  = {bit_in, shreg_q[7:1]};
        byte_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      byte_data_q  <= 8'h00;
      byte_valid_q <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;

endmodule

// File: rtl/lfsr_keystream.sv
// Galois LFSR keystream: one bit per valid/ready handshake, bytes assembled for wide consumers.
// Load has priority over stepping and takes effect in one cycle; ks_bit comes straight from the state register.
module lfsr_keystream
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS         = LFSR_TAPS,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = LFSR_DEFSEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             ks_ready,
  output logic             ks_bit,
  output logic             ks_valid,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic [WIDTH-1:0] state_out
);

  ks_state_e        fsm_q,   fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic             step;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    step    = 1'b0;
    if (load) begin
      // A zero seed would lock the LFSR at zero forever.
      state_d = (seed == '0) ? DEFAULT_SEED : seed;
      fsm_d   = ST_RUN;
    end else if ((fsm_q == ST_RUN) && ks_ready) begin
      step    = 1'b1;
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
    end
  end

  assign ks_bit    = state_q[0];
  assign ks_valid  = (fsm_q == ST_RUN);
  assign state_out = state_q;

  ks_byte_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (state_q[0]),
    .shift      (step),
    .clear      (load),
    .byte_data  (byte_data),
    .byte_valid (byte_valid)
  );

endmodule

// File: doc/lfsr_keystream.md
# lfsr_keystream

Bit-serial keystream generator for the crypto datapath: a Galois LFSR whose output bit drives the select input of the downstream 2:1 mux stage, one bit per accepted handshake. Also assembles consumed bits into bytes for byte-wide consumers and debug. Sits directly upstream of the mux; seed and step control come from the controller.

## Interface
- WIDTH, 16, LFSR state width in bits.
- TAPS, 16'hB400, Galois feedback mask for x^16+x^14+x^13+x^11+1, giving a maximal period of 65535.
- DEFAULT_SEED, 16'hACE1, state substituted when a zero seed is loaded.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  loads seed on this edge; has priority over stepping.
- seed  in  WIDTH  seed value, sampled when load=1.
- ks_ready  in  1  downstream accepts the current ks_bit.
- ks_bit  out  1  current keystream bit, equal to state[0]; drives the downstream mux select.
- ks_valid  out  1  ks_bit is valid; high only in RUN.
- byte_data  out  8  last completed byte; the first consumed bit is placed in bit 0.
- byte_valid  out  1  one-cycle pulse when byte_data updates.
- state_out  out  WIDTH  raw LFSR state, for observability.

## Operation
- The FSM has two states, IDLE and RUN. Reset enters IDLE.
- IDLE:
  - ks_valid=0.
  - ks_ready is ignored.
  - load moves the FSM to RUN.
- RUN:
  - ks_valid=1.
  - A step occurs when ks_valid && ks_ready && !load. It performs state <= (state >> 1) ^ (state[0] ? TAPS : 0).
  - A step also shifts the consumed bit into the byte assembler.
- load, in any state:
  - state <= (seed == 0) ? DEFAULT_SEED : seed.
  - bit_cnt <= 0 and the partial byte is discarded.
  - The FSM goes to (or stays in) RUN.
  - byte_valid=0 on that edge.
- Byte assembler:
  - 3-bit bit_cnt and an 8-bit shift register.
  - Bit k of a byte, for k = 0..7, is the k-th bit consumed since the last byte or load.
  - On the step with bit_cnt==7: byte_data <= the completed byte, byte_valid=1 for the next cycle, and bit_cnt wraps to 0.
- Stall: when ks_ready=0, state, ks_bit, bit_cnt and byte_data all hold, and byte_valid=0.
- The LFSR never reaches all-zero state: a zero seed is replaced, and the Galois update cannot produce zero from a nonzero state.
- Width rules:
  - Arithmetic is unsigned.
  - bit_cnt wraps modulo 8.
  - There is no other counter.

## Timing
- Reset values:
  - FSM=IDLE, state=0, ks_bit=0, ks_valid=0.
  - byte_data=8'h00, byte_valid=0, bit_cnt=0.
  - state_out=0.
- Load latency is 1 cycle. After the load edge, ks_valid=1 and ks_bit = bit 0 of the seed (or of DEFAULT_SEED).
- ks_bit is a direct function of the state register, with no combinational path from ks_ready.
- Throughput is one bit per cycle while ks_ready stays high.
- byte_valid is registered. It asserts the cycle after the 8th accepting edge and lasts exactly one cycle unless the next byte also completes.
- Simultaneous load and ks_ready:
  - The load wins and no step occurs.
  - The bit presented in that cycle counts as not consumed.
- rst mid-byte:
  - All outputs return to their reset values on that edge.
  - The partial byte is lost.
- rst has priority over load.

## Structure
- Shared package lfsr_pkg holds:
  - The TAPS and DEFAULT_SEED constants for the 16-bit polynomial.
  - The FSM state encoding (IDLE=1'b0, RUN=1'b1).
- One natural sub-module, ks_byte_pack: the 8-bit serial-to-parallel assembler, with bit_in, shift, clear, byte_data and byte_valid.
- The top level contains only the LFSR register, the FSM and the handshake logic.

## Test plan
- Reset: assert rst with load=1 and ks_ready=1 -> after the edge, every output is at its reset value and ks_valid=0; ks_ready in IDLE causes no change.
- Seed 16'h0001, ks_ready held high, 16 cycles:
  - Consumed ks_bit = 1,0,0,0,0,0,0,0, then 0,0,0,1,0,1,1,0.
  - byte_valid pulses twice, with byte_data=8'h01 then 8'h68.
  - state_out = 16'h0168 after 8 steps and 16'h7C41 after 16 steps.
- Stall: seed 16'h0001, toggle ks_ready 1,0,0,1,... -> state_out and bit_cnt hold during the zeros, and the bit sequence and byte values are identical to the previous scenario.
- Zero seed: load seed=0 -> state_out=16'hACE1 and ks_bit=1; ks_valid=1.
- Load collision: after 5 consumed bits, assert load=1 (seed=16'h0001) with ks_ready=1 -> no step, partial byte discarded, and the next byte_data is 8'h01 after 8 further accepted bits.
- Period: seed 16'h0001, ks_ready held high -> state_out first returns to 16'h0001 after exactly 65535 steps and is never 0.
